// File: rtl/cpu_defs.sv
// Shared opcode constants, FSM state encoding and control-word layout for the CPU.
// Used by the control unit, the datapath and the benches.
package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    // One-hot instruction class bit positions; NOP also covers undefined opcodes.
    localparam int CLS_W    = 10;
    localparam int CLS_LD   = 0;
    localparam int CLS_LDI  = 1;
    localparam int CLS_ST   = 2;
    localparam int CLS_ADD  = 3;
    localparam int CLS_SUB  = 4;
    localparam int CLS_ADDI = 5;
    localparam int CLS_BR   = 6;
    localparam int CLS_JR   = 7;
    localparam int CLS_HALT = 8;
    localparam int CLS_NOP  = 9;

    typedef struct packed {
        logic pc_out, zlow_out, zhigh_out, mdr_out, c_out, in_port_out, lo_out, hi_out, r_out, ba_out;
        logic mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, c_in, in_in, out_in, con_in, r_in;
        logic inc_pc, read, write, gra, grb, grc, add, subtract, multiply, divide;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Maps the opcode field to a one-hot instruction class.
// Purely combinational; no storage, no flow control.
module instr_decode
    import cpu_defs::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0]  i_opcode,
    output logic [CLS_W-1:0] o_cls
);

    always_comb begin
        o_cls = '0;
        case (i_opcode)
            OP_LD:   o_cls[CLS_LD]   = 1'b1;
            OP_LDI:  o_cls[CLS_LDI]  = 1'b1;
            OP_ST:   o_cls[CLS_ST]   = 1'b1;
            OP_ADD:  o_cls[CLS_ADD]  = 1'b1;
            OP_SUB:  o_cls[CLS_SUB]  = 1'b1;
            OP_ADDI: o_cls[CLS_ADDI] = 1'b1;
            OP_BR:   o_cls[CLS_BR]   = 1'b1;
            OP_JR:   o_cls[CLS_JR]   = 1'b1;
            OP_HALT: o_cls[CLS_HALT] = 1'b1;
            default: o_cls[CLS_NOP]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch in T0-T2, execute in T3-T7, 3 to 8 cycles per instruction.
// Controls are a pure decode of state, opcode and con_ff; clr forces RST asynchronously.
module control_unit
    import cpu_defs::*;
#(
    parameter int IR_W = 32,
    parameter int OP_W = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            stop,
    input  logic [IR_W-1:0] ir,
    input  logic            con_ff,
    output logic            run,
    output logic            PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, Rout, BAout,
    output logic            MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn, RIn,
    output logic            IncPC, read, write, Gra, Grb, Grc, add, subtract, multiply, divide
);

    state_t            r_state;
    state_t            w_next;
    ctrl_t             w_c;
    logic              w_run;
    logic              w_fin;
    logic [CLS_W-1:0]  w_cls;
    logic              w_mem_cls;

    instr_decode #(.OP_W(OP_W)) u_decode (
        .i_opcode (ir[IR_W-1 -: OP_W]),
        .o_cls    (w_cls)
    );

    // ld, ldi and st share the effective-address computation in T3/T4.
    assign w_mem_cls = w_cls[CLS_LD] | w_cls[CLS_LDI] | w_cls[CLS_ST];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_RST;
        else     r_state <= w_next;
    end

    always_comb begin
        w_c   = '0;
        w_run = 1'b1;
        w_fin = 1'b0;
        w_next = S_RST;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0: begin
                w_c.pc_out = 1'b1; w_c.mar_in = 1'b1; w_c.inc_pc = 1'b1; w_c.z_in = 1'b1;
                w_next = S_T1;
            end
            S_T1: begin
                w_c.zlow_out = 1'b1; w_c.pc_in = 1'b1; w_c.read = 1'b1; w_c.mdr_in = 1'b1;
                w_next = S_T2;
            end
            S_T2: begin
                w_c.mdr_out = 1'b1; w_c.ir_in = 1'b1;
                w_next = S_T3;
                if (w_cls[CLS_HALT])     w_next = S_HALT;
                else if (w_cls[CLS_NOP]) w_fin = 1'b1;
            end
            S_T3: begin
                w_next = S_T4;
                if (w_mem_cls) begin
                    w_c.grb = 1'b1; w_c.ba_out = 1'b1; w_c.y_in = 1'b1;
                end else if (w_cls[CLS_ADD] | w_cls[CLS_SUB] | w_cls[CLS_ADDI]) begin
                    w_c.grb = 1'b1; w_c.r_out = 1'b1; w_c.y_in = 1'b1;
                end else if (w_cls[CLS_BR]) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.con_in = 1'b1;
                end else if (w_cls[CLS_JR]) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.pc_in = 1'b1;
                    w_fin = 1'b1;
                end
            end
            S_T4: begin
                w_next = S_T5;
                if (w_mem_cls | w_cls[CLS_ADDI]) begin
                    w_c.c_out = 1'b1; w_c.add = 1'b1; w_c.z_in = 1'b1;
                end else if (w_cls[CLS_ADD] | w_cls[CLS_SUB]) begin
                    w_c.grc = 1'b1; w_c.r_out = 1'b1; w_c.z_in = 1'b1;
                    w_c.add = w_cls[CLS_ADD]; w_c.subtract = w_cls[CLS_SUB];
                end else if (w_cls[CLS_BR]) begin
                    w_c.pc_out = 1'b1; w_c.y_in = 1'b1;
                end
            end
            S_T5: begin
                w_next = S_T6;
                if (w_cls[CLS_LD] | w_cls[CLS_ST]) begin
                    w_c.zlow_out = 1'b1; w_c.mar_in = 1'b1;
                end else if (w_cls[CLS_BR]) begin
                    w_c.c_out = 1'b1; w_c.add = 1'b1; w_c.z_in = 1'b1;
                end else begin
                    w_c.zlow_out = 1'b1; w_c.gra = 1'b1; w_c.r_in = 1'b1;
                    w_fin = 1'b1;
                end
            end
            S_T6: begin
                w_next = S_T7;
                if (w_cls[CLS_LD]) begin
                    w_c.read = 1'b1; w_c.mdr_in = 1'b1;
                end else if (w_cls[CLS_ST]) begin
                    w_c.gra = 1'b1; w_c.r_out = 1'b1; w_c.mdr_in = 1'b1;
                end else begin
                    w_c.zlow_out = con_ff; w_c.pc_in = con_ff;
                    w_fin = 1'b1;
                end
            end
            S_T7: begin
                w_c.mdr_out = 1'b1;
                w_c.gra   = w_cls[CLS_LD]; w_c.r_in = w_cls[CLS_LD];
                w_c.write = w_cls[CLS_ST];
                w_fin = 1'b1;
            end
            S_HALT: begin
                w_run  = 1'b0;
                w_next = S_HALT;
            end
            default: w_next = S_RST;
        endcase
        // Instruction boundary: honour a pending stop request here and only here.
        if (w_fin) w_next = stop ? S_HALT : S_T0;
    end

    assign run        = w_run;
    assign PCout      = w_c.pc_out;
    assign Zlowout    = w_c.zlow_out;
    assign Zhighout   = w_c.zhigh_out;
    assign MDRout     = w_c.mdr_out;
    assign Cout       = w_c.c_out;
    assign IN_Portout = w_c.in_port_out;
    assign LOout      = w_c.lo_out;
    assign HIout      = w_c.hi_out;
    assign Rout       = w_c.r_out;
    assign BAout      = w_c.ba_out;
    assign MARIn      = w_c.mar_in;
    assign PCIn       = w_c.pc_in;
    assign MDRIn      = w_c.mdr_in;
    assign IRIn       = w_c.ir_in;
    assign YIn        = w_c.y_in;
    assign ZIn        = w_c.z_in;
    assign HiIn       = w_c.hi_in;
    assign LoIn       = w_c.lo_in;
    assign CIn        = w_c.c_in;
    assign InIn       = w_c.in_in;
    assign OutIn      = w_c.out_in;
    assign CONIn      = w_c.con_in;
    assign RIn        = w_c.r_in;
    assign IncPC      = w_c.inc_pc;
    assign read       = w_c.read;
    assign write      = w_c.write;
    assign Gra        = w_c.gra;
    assign Grb        = w_c.grb;
    assign Grc        = w_c.grc;
    assign add        = w_c.add;
    assign subtract   = w_c.subtract;
    assign multiply   = w_c.multiply;
    assign divide     = w_c.divide;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus random instruction streams,
// each control vector compared against a per-instruction step plan.
module tb_control_unit;

    localparam int NSIG = 33;
    localparam int PCOUT = 0, ZLOWOUT = 1, MDROUT = 3, COUT = 4, ROUT = 8, BAOUT = 9;
    localparam int MARIN = 10, PCIN = 11, MDRIN = 12, IRIN = 13, YIN = 14, ZIN = 15;
    localparam int CONIN = 21, RIN = 22, INCPC = 23, READ = 24, WRITE = 25;
    localparam int GRA = 26, GRB = 27, GRC = 28, ADD = 29, SUB = 30;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        stop = 1'b0;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        run;
    logic        PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, Rout, BAout;
    logic        MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn, RIn;
    logic        IncPC, read, write, Gra, Grb, Grc, add, subtract, multiply, divide;
    logic [NSIG:0] obs;

    int errors = 0;
    int checks = 0;

    logic [NSIG-1:0] plan_m [8];
    int              plan_len;
    logic            plan_halt;

    control_unit #(.IR_W(32), .OP_W(5)) dut (
        .clk(clk), .clr(clr), .stop(stop), .ir(ir), .con_ff(con_ff), .run(run),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
        .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout), .Rout(Rout), .BAout(BAout),
        .MARIn(MARIn), .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .ZIn(ZIn),
        .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn), .InIn(InIn), .OutIn(OutIn), .CONIn(CONIn), .RIn(RIn),
        .IncPC(IncPC), .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .add(add), .subtract(subtract), .multiply(multiply), .divide(divide)
    );

    always #5 clk = ~clk;

    assign obs = {run, divide, multiply, subtract, add, Grc, Grb, Gra, write, read, IncPC,
                  RIn, CONIn, OutIn, InIn, CIn, LoIn, HiIn, ZIn, YIn, IRIn, MDRIn, PCIn, MARIn,
                  BAout, Rout, HIout, LOout, IN_Portout, Cout, MDRout, Zhighout, Zlowout, PCout};

    function automatic logic [NSIG-1:0] m(input int i);
        logic [NSIG-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic chk(input string tag, input logic [NSIG:0] got, input logic [NSIG:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected control word for each cycle of one instruction, T0 first.
    task automatic set_plan(input logic [4:0] op, input logic con);
        logic [NSIG-1:0] ea3, ea4, wb5, alu3;
        for (int i = 0; i < 8; i++) plan_m[i] = '0;
        plan_m[0] = m(PCOUT) | m(MARIN) | m(INCPC) | m(ZIN);
        plan_m[1] = m(ZLOWOUT) | m(PCIN) | m(READ) | m(MDRIN);
        plan_m[2] = m(MDROUT) | m(IRIN);
        ea3  = m(GRB) | m(BAOUT) | m(YIN);
        ea4  = m(COUT) | m(ADD) | m(ZIN);
        wb5  = m(ZLOWOUT) | m(GRA) | m(RIN);
        alu3 = m(GRB) | m(ROUT) | m(YIN);
        plan_len  = 3;
        plan_halt = 1'b0;
        case (op)
            5'd0: begin plan_len = 8; plan_m[3] = ea3; plan_m[4] = ea4;
                  plan_m[5] = m(ZLOWOUT) | m(MARIN); plan_m[6] = m(READ) | m(MDRIN);
                  plan_m[7] = m(MDROUT) | m(GRA) | m(RIN); end
            5'd1: begin plan_len = 6; plan_m[3] = ea3; plan_m[4] = ea4; plan_m[5] = wb5; end
            5'd2: begin plan_len = 8; plan_m[3] = ea3; plan_m[4] = ea4;
                  plan_m[5] = m(ZLOWOUT) | m(MARIN); plan_m[6] = m(GRA) | m(ROUT) | m(MDRIN);
                  plan_m[7] = m(MDROUT) | m(WRITE); end
            5'd3, 5'd4: begin plan_len = 6; plan_m[3] = alu3;
                  plan_m[4] = m(GRC) | m(ROUT) | m(ZIN) | ((op == 5'd3) ? m(ADD) : m(SUB));
                  plan_m[5] = wb5; end
            5'd12: begin plan_len = 6; plan_m[3] = alu3; plan_m[4] = ea4; plan_m[5] = wb5; end
            5'd18: begin plan_len = 7; plan_m[3] = m(GRA) | m(ROUT) | m(CONIN);
                  plan_m[4] = m(PCOUT) | m(YIN); plan_m[5] = ea4;
                  plan_m[6] = con ? (m(ZLOWOUT) | m(PCIN)) : '0; end
            5'd20: begin plan_len = 4; plan_m[3] = m(GRA) | m(ROUT) | m(PCIN); end
            5'd27: plan_halt = 1'b1;
            default: ;
        endcase
    endtask

    // clr pulse from a negedge; the following posedge leaves RST for T0.
    task automatic recover();
        @(negedge clk);
        clr = 1'b1;
        #1 chk("clr_recover", obs, {1'b1, {NSIG{1'b0}}});
        @(negedge clk);
        clr = 1'b0;
        stop = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] instr, input logic con, input int stop_step,
                             input int clr_step);
        set_plan(instr[31:27], con);
        for (int s = 0; s < plan_len; s++) begin
            @(negedge clk);
            if (s == 0) begin ir = instr; con_ff = con; end
            if (stop_step >= 0 && s >= stop_step) stop = 1'b1;
            #1 chk($sformatf("op%0d T%0d", instr[31:27], s), obs, {1'b1, plan_m[s]});
            if (s == clr_step) begin
                #1 clr = 1'b1;
                #1 chk("clr_async", obs, {1'b1, {NSIG{1'b0}}});
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1 chk("clr_hold_nowrite", {write, RIn}, 2'b00);
                end
                clr = 1'b0;
                @(negedge clk);
                #1 chk("after_clr_T0", obs, {1'b1, plan_m[0]});
                @(negedge clk);
                #1 chk("after_clr_T1", obs, {1'b1, m(ZLOWOUT) | m(PCIN) | m(READ) | m(MDRIN)});
                recover();
                return;
            end
        end
        if (plan_halt || stop_step >= 0) begin
            for (int k = 0; k < (plan_halt ? 10 : 3); k++) begin
                @(negedge clk);
                #1 chk("halt_hold", obs, '0);
            end
            recover();
        end
    endtask

    initial begin
        logic [4:0] ops [10];
        logic [4:0] op;
        logic [31:0] instr;
        int sstep;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd12, 5'd18, 5'd20, 5'd26, 5'd27};

        @(negedge clk);
        #1 chk("reset_state", obs, {1'b1, {NSIG{1'b0}}});
        @(negedge clk);
        #1 chk("reset_hold", obs, {1'b1, {NSIG{1'b0}}});
        clr = 1'b0;

        run_instr(32'h1000_0000, 1'b0, -1, -1);
        run_instr(32'h0000_0000, 1'b0, -1, -1);
        run_instr(32'h9000_0000, 1'b0, -1, -1);
        run_instr(32'h9000_0000, 1'b1, -1, -1);
        run_instr(32'hA000_0000, 1'b0, -1, -1);
        run_instr(32'hD000_0000, 1'b0, -1, -1);
        run_instr(32'hF800_0000, 1'b0, -1, -1);
        run_instr(32'h2000_0000, 1'b0, -1, -1);
        run_instr(32'h6000_0000, 1'b0, -1, -1);
        run_instr(32'h1800_0000, 1'b0, 4, -1);
        run_instr(32'hD800_0000, 1'b0, -1, -1);
        run_instr(32'h1000_0000, 1'b0, -1, 6);
        run_instr(32'hD000_0000, 1'b0, 2, -1);
        run_instr(32'hA000_0000, 1'b1, 3, -1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(0, 31));
            else                           op = ops[$urandom_range(0, 9)];
            instr = {op, 27'($urandom)};
            set_plan(op, 1'b0);
            sstep = ($urandom_range(0, 7) == 0) ? $urandom_range(0, plan_len - 1) : -1;
            run_instr(instr, 1'($urandom_range(0, 1)), sstep, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter IR_W, default 32, instruction register width.
REQ-002 Parameter OP_W, default 5, opcode width; opcode is ir[31:27].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 stop  input  1  request halt at next instruction boundary.
REQ-006 ir  input  IR_W  current instruction from the datapath IR.
REQ-007 con_ff  input  1  branch-condition flip-flop from the datapath.
REQ-008 run  output  1  high unless in HALT.
REQ-009 PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout, Rout, BAout  output  1 each  bus-source enables.
REQ-010 MARIn, PCIn, MDRIn, IRIn, YIn, ZIn, HiIn, LoIn, CIn, InIn, OutIn, CONIn, RIn  output  1 each  register load enables.
REQ-011 IncPC, read, write, Gra, Grb, Grc, add, subtract, multiply, divide  output  1 each  ALU, memory and register-select controls.

Function
REQ-012 States SHALL be RST, T0..T7, HALT; exactly one state per clk cycle; outputs are a decode of state, ir[31:27] and con_ff only.
REQ-013 Every output not listed for the current state SHALL be 0.
REQ-014 RST: all controls 0, run=1; next state T0.
REQ-015 T0: PCout, MARIn, IncPC, ZIn. T1: Zlowout, PCIn, read, MDRIn. T2: MDRout, IRIn.
REQ-016 Opcode decode SHALL occur in T3 using ir as loaded at the end of T2.
REQ-017 ld (00000): T3 Grb BAout YIn; T4 Cout add ZIn; T5 Zlowout MARIn; T6 read MDRIn; T7 MDRout Gra RIn.
REQ-018 ldi (00001): T3 Grb BAout YIn; T4 Cout add ZIn; T5 Zlowout Gra RIn.
REQ-019 st (00010): T3 Grb BAout YIn; T4 Cout add ZIn; T5 Zlowout MARIn; T6 Gra Rout MDRIn; T7 MDRout write.
REQ-020 add (00011)/sub (00100): T3 Grb Rout YIn; T4 Grc Rout ZIn plus add or subtract; T5 Zlowout Gra RIn.
REQ-021 addi (01100): T3 Grb Rout YIn; T4 Cout add ZIn; T5 Zlowout Gra RIn.
REQ-022 br (10010): T3 Gra Rout CONIn; T4 PCout YIn; T5 Cout add ZIn; T6 Zlowout and PCIn only if con_ff=1, else all 0.
REQ-023 jr (10100): T3 Gra Rout PCIn.
REQ-024 nop (11010) and every undefined opcode SHALL end after T2 (T2 -> T0).
REQ-025 halt (11011): T2 -> HALT; HALT holds all controls 0, run=0, until clr.
REQ-026 The final state of each instruction SHALL go to T0, or to HALT if stop=1 in that cycle.
REQ-027 stop asserted mid-instruction SHALL not truncate it; the instruction completes first.
REQ-028 Latency: ld/st 8 cycles, br 7, ldi/add/sub/addi 6, jr 4, nop 3 (T0-inclusive).

Reset
REQ-029 clr=1 SHALL force state RST immediately, regardless of clk, and clear all controls combinationally.
REQ-030 clr asserted mid-instruction SHALL abandon it; no write or RIn may occur after clr rises.
REQ-031 First rising clk with clr=0 SHALL move RST -> T0.

Structure
REQ-032 Opcode constants and state encodings SHALL live in shared package cpu_defs, also used by the datapath and benches.
REQ-033 One sub-module, instr_decode, SHALL map ir[31:27] to a one-hot instruction class; the FSM SHALL be in control_unit.
REQ-034 State register SHALL be the only storage in the block.

Verification
REQ-035 clr pulse then ir=0x1000_0000 (st) -> states T0..T7 in 8 cycles; write=1 only in T7, MDRout=1 in T7.
REQ-036 ir=0x0000_0000 (ld) -> read=1 in T1 and T6, RIn=1 with Gra=1 only in T7.
REQ-037 ir=0x9000_0000 (br), con_ff=0 -> no PCIn in T6; repeat with con_ff=1 -> PCIn=1, Zlowout=1 in T6.
REQ-038 ir=0xD800_0000 (halt) -> HALT after T2, run=0, all controls 0 for 10 cycles; clr -> run=1, T0 next cycle.
REQ-039 stop=1 raised in T4 of add (ir=0x1800_0000) -> T5 still asserts Gra RIn, then HALT.
REQ-040 clr raised in T6 of st -> controls 0 immediately, write never asserted, T0 after clr falls.
